// File: rtl/alu_seq_pkg.sv
// Shared op codes, ALU select codes, FSM states and default width for the sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_seq_pkg;

  localparam int DEFAULT_W = 24;

  // Command op codes; anything not listed here is illegal.
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  // ALU result select.
  localparam logic [1:0] SEL_AND  = 2'b00;
  localparam logic [1:0] SEL_OR   = 2'b01;
  localparam logic [1:0] SEL_SUM  = 2'b10;
  localparam logic [1:0] SEL_LESS = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_SLT2 = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic op_legal(input logic [2:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: op_legal = 1'b1;
      default:                               op_legal = 1'b0;
    endcase
  endfunction

  // Only ADD and SUB report carry-out and signed overflow.
  function automatic logic op_arith(input logic [2:0] op);
    op_arith = (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_24bit.sv
// Combinational ALU: AND / OR / add-subtract / set-less-than pass-through.
// Latency: zero cycles, purely combinational.
// Backpressure: none; outputs follow inputs.
module alu_24bit #(
  parameter int W = alu_seq_pkg::DEFAULT_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   sel,
  input  logic         binv,
  input  logic         cin,
  input  logic         less,
  output logic [W-1:0] result,
  output logic         co,
  output logic         ovf
);
  import alu_seq_pkg::*;

  logic [W-1:0] b_eff;
  logic [W:0]   sum_full;

  assign b_eff    = binv ? ~b : b;
  assign sum_full = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, cin};
  assign co       = sum_full[W];
  // Signed overflow: operands agree in sign but the sum does not.
  assign ovf      = (a[W-1] == b_eff[W-1]) && (sum_full[W-1] != a[W-1]);

  // Select the result source.
  always_comb begin
    result = '0;
    case (sel)
      SEL_AND:  result = a & b_eff;
      SEL_OR:   result = a | b_eff;
      SEL_SUM:  result = sum_full[W-1:0];
      default:  result = {{(W-1){1'b0}}, less};
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command/response sequencer driving one shared ALU through IDLE/EXEC/SLT2/DONE.
// Latency: response 2 cycles after accept (AND/OR/ADD/SUB), 3 (SLT), 1 (illegal op).
// Backpressure: valid/ready both sides; one command in flight, response held until taken.
module alu_op_sequencer #(
  parameter int W = alu_seq_pkg::DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_result,
  output logic         rsp_co,
  output logic         rsp_ovf,
  output logic         rsp_zero,
  output logic         rsp_err
);
  import alu_seq_pkg::*;

  state_t state, state_nxt;

  logic [2:0]   op_q;
  logic [W-1:0] a_q, b_q;
  logic [W-1:0] result_q;
  logic         co_q;
  logic         less_q;

  logic [1:0]   alu_sel;
  logic         alu_binv, alu_cin, alu_less;
  logic [W-1:0] alu_result;
  logic         alu_co, alu_ovf;

  logic         accept;
  logic         in_done;
  logic         b_sign;

  assign accept  = cmd_valid && cmd_ready;
  assign in_done = (state == S_DONE);

  alu_24bit #(.W(W)) u_alu (
    .a      (a_q),
    .b      (b_q),
    .sel    (alu_sel),
    .binv   (alu_binv),
    .cin    (alu_cin),
    .less   (alu_less),
    .result (alu_result),
    .co     (alu_co),
    .ovf    (alu_ovf)
  );

  // State register; reset drops any in-flight command immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = op_legal(cmd_op) ? S_EXEC : S_DONE;
      S_EXEC: state_nxt = (op_q == OP_SLT) ? S_SLT2 : S_DONE;
      S_SLT2: state_nxt = S_DONE;
      S_DONE: if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand capture on accept, result/carry/less capture as the op executes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      co_q     <= 1'b0;
      less_q   <= 1'b0;
    end else if (accept) begin
      op_q     <= cmd_op;
      a_q      <= cmd_a;
      b_q      <= cmd_b;
      result_q <= '0;
      co_q     <= 1'b0;
      less_q   <= 1'b0;
    end else if (state == S_EXEC) begin
      if (op_q == OP_SLT) begin
        // Sign of the difference corrected by overflow gives the true signed compare.
        less_q <= alu_result[W-1] ^ alu_ovf;
      end else begin
        result_q <= alu_result;
        co_q     <= op_arith(op_q) ? alu_co : 1'b0;
      end
    end else if (state == S_SLT2) begin
      result_q <= alu_result;
      co_q     <= 1'b0;
    end
  end

  // Handshake outputs, ALU controls and response flags.
  always_comb begin
    cmd_ready  = (state == S_IDLE) && !rst;
    rsp_valid  = in_done;

    alu_sel    = SEL_SUM;
    alu_binv   = 1'b0;
    alu_cin    = 1'b0;
    alu_less   = less_q;
    if (state == S_SLT2) begin
      alu_sel  = SEL_LESS;
      alu_binv = 1'b1;
      alu_cin  = 1'b1;
    end else begin
      case (op_q)
        OP_AND: alu_sel = SEL_AND;
        OP_OR:  alu_sel = SEL_OR;
        OP_SUB, OP_SLT: begin
          alu_sel  = SEL_SUM;
          alu_binv = 1'b1;
          alu_cin  = 1'b1;
        end
        default: alu_sel = SEL_SUM;
      endcase
    end

    // Overflow is derived from stored operands and result rather than kept in a flop.
    b_sign     = (op_q == OP_SUB) ? ~b_q[W-1] : b_q[W-1];
    rsp_result = in_done ? result_q : '0;
    rsp_co     = in_done && co_q;
    rsp_ovf    = in_done && op_arith(op_q) && (a_q[W-1] == b_sign) &&
                 (result_q[W-1] != a_q[W-1]);
    rsp_zero   = in_done && op_legal(op_q) && (result_q == '0);
    rsp_err    = in_done && !op_legal(op_q);
  end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001: Parameter W, default 24, datapath width in bits.
REQ-002: clk  input  1  single clock; all state on rising edge.
REQ-003: rst  input  1  reset, asynchronous and active-high.
REQ-004: cmd_valid  input  1  command present.
REQ-005: cmd_ready  output  1  sequencer can accept a command.
REQ-006: cmd_op  input  3  operation code, see REQ-012.
REQ-007: cmd_a, cmd_b  input  W  operands, two's complement.
REQ-008: rsp_valid  output  1  response present.
REQ-009: rsp_ready  input  1  consumer accepts response.
REQ-010: rsp_result  output  W  operation result.
REQ-011: rsp_co, rsp_ovf, rsp_zero, rsp_err  output  1 each  carry-out, signed overflow, result==0, illegal op.

Function
REQ-012: Op codes: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; all other codes illegal.
REQ-013: ALU controls per op: AND sel=00; OR sel=01; ADD sel=10, binv=0, cin=0; SUB sel=10, binv=1, cin=1; SLT pass 1 as SUB, pass 2 sel=11, binv=1, cin=1, less=pass-1 flag in bit 0, zeros above.
REQ-014: FSM states IDLE, EXEC, SLT2, DONE; reset state IDLE.
REQ-015: cmd_ready=1 only in IDLE; handshake completes when cmd_valid and cmd_ready are both 1 on a clock edge.
REQ-016: On accept, register op/a/b; legal op -> EXEC, illegal op -> DONE with rsp_err=1, rsp_result=0, other flags 0.
REQ-017: EXEC drives ALU from registered operands; for non-SLT, capture result/co at end of cycle -> DONE; for SLT, capture less flag = sign(diff) XOR ovf -> SLT2.
REQ-018: SLT2 drives pass 2 and captures result -> DONE.
REQ-019: Latency from accept edge N: rsp_valid high from edge N+2 (AND/OR/ADD/SUB), N+3 (SLT), N+1 (illegal).
REQ-020: rsp_ovf = (a[W-1]==b'[W-1]) and (result[W-1]!=a[W-1]), where b' = b inverted when binv=1; ADD/SUB only, else 0; rsp_co valid for ADD/SUB only, else 0.
REQ-021: rsp_zero = (rsp_result==0) for all legal ops.
REQ-022: DONE holds rsp_valid and all rsp_* stable until rsp_ready=1; transfer edge -> IDLE.
REQ-023: rsp_ready ignored outside DONE; cmd_valid ignored outside IDLE; no command is lost or duplicated.
REQ-024: Maximum throughput one command per 3 cycles (non-SLT), 4 cycles (SLT), with rsp_ready held high.

Reset
REQ-025: rst asserted, at any time including mid-operation, forces IDLE immediately, without waiting for a clock edge.
REQ-026: Reset values: cmd_ready=0 while rst is high, 1 on the first cycle after release; rsp_valid=0; rsp_result=0; all flags 0.
REQ-027: An in-flight command is discarded by reset; no response is produced for it.

Structure
REQ-028: Op codes, state encodings and default W live in shared package alu_seq_pkg.
REQ-029: One sub-module instance, alu_24bit, supplies the combinational datapath; the sequencer contains no duplicate adder.
REQ-030: Result, co and SLT flag registers are the only datapath storage besides the operand registers.

Verification
REQ-031: ADD a=0xAAAAAA, b=0x555555 -> result 0xFFFFFF, co=0, ovf=0, zero=0, rsp_valid at N+2.
REQ-032: SUB a=0x123456, b=0x654321 -> result 0xACF135, co=0, ovf=0; AND a=0xAAAAAA, b=0x555555 -> result 0, zero=1.
REQ-033: SLT a=0x800000, b=0x000001 -> result 0x000001, using the overflow correction, rsp_valid at N+3; SLT a=0x654321, b=0x123456 -> result 0, zero=1.
REQ-034: ADD 0x7FFFFF+0x000001 -> result 0x800000, ovf=1; illegal op 011 -> rsp_err=1, result 0, rsp_valid at N+1.
REQ-035: Hold rsp_ready=0 for 5 cycles in DONE -> rsp_* stable and cmd_ready=0 throughout; rsp_ready=1 -> IDLE next cycle.
REQ-036: Assert rst during EXEC of an SLT -> rsp_valid stays 0, FSM in IDLE; next ADD 1+1 -> result 0x000002.
